// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, syncs and pixel qualifiers.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   Hcnt, Vcnt   current pixel column / line (11 bit)
//   hsync/vsync  sync outputs, active level set by H_POL / V_POL
//   video_on     high inside the visible area
//   pix_tick     one-clock pulse in the cycle the position changes
//   frame_start  pix_tick qualified by the position becoming (0,0)
//   frame_cnt    frames started since reset, wraps at 255
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 56,
    parameter int unsigned H_SYNC   = 120,
    parameter int unsigned H_BP     = 64,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 37,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 23,
    parameter int unsigned H_POL    = 1,
    parameter int unsigned V_POL    = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] Hcnt,
    output logic [10:0] Vcnt,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        pix_tick,
    output logic        frame_start,
    output logic [7:0]  frame_cnt
);

    localparam int unsigned CNT_W   = 11;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic             HP       = 1'(H_POL);
    localparam logic             VP       = 1'(V_POL);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic             adv;
    logic             h_wrap;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             hs_nxt;
    logic             vs_nxt;
    logic             von_nxt;
    logic             fs_nxt;

    // Next position and the qualifiers that will describe it, so every
    // registered output refers to the same pixel in the same cycle.
    always_comb begin
        adv     = (div == DIV_LAST);
        div_nxt = adv ? '0 : div + DIV_W'(1);
        h_wrap  = (Hcnt == H_LAST);
        h_nxt   = h_wrap ? '0 : Hcnt + CNT_W'(1);
        v_nxt   = Vcnt;
        if (h_wrap) begin
            v_nxt = (Vcnt == V_LAST) ? '0 : Vcnt + CNT_W'(1);
        end
        hs_nxt  = ((h_nxt >= HS_BEG) && (h_nxt < HS_END)) ? HP : ~HP;
        vs_nxt  = ((v_nxt >= VS_BEG) && (v_nxt < VS_END)) ? VP : ~VP;
        von_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
        fs_nxt  = (h_nxt == '0) && (v_nxt == '0);
    end

    // Reset parks on the last blanked pixel so the first advance lands on (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div         <= '0;
            Hcnt        <= H_LAST;
            Vcnt        <= V_LAST;
            hsync       <= ~HP;
            vsync       <= ~VP;
            video_on    <= 1'b0;
            pix_tick    <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            div         <= div_nxt;
            pix_tick    <= adv;
            frame_start <= adv && fs_nxt;
            if (adv) begin
                Hcnt     <= h_nxt;
                Vcnt     <= v_nxt;
                hsync    <= hs_nxt;
                vsync    <= vs_nxt;
                video_on <= von_nxt;
                if (fs_nxt) begin
                    frame_cnt <= frame_cnt + 8'(1);
                end
            end
        end
    end

endmodule
